config_shift_master: RTL and testbench
======================================

Name: config_shift_master

Overview:
Serial master for the configuration shift chain. It accepts a parallel configuration word from the host-side controller and drives serialEn/serialIn to shift the word into the chain, MSB first. While shifting, it captures the chain's serialOut, so the previous chain contents come back as a readback word. A rotate mode feeds serialOut back into serialIn, which reads the chain without changing it.

Parameters:
ChainLength, 5, total chain bits (clock-config width 4 + sym-coeffs width 1); must be >= 2
StepCycles, 1, clk cycles between consecutive shift pulses; must be >= 1
StepCntWidth, $clog2(StepCycles+1), width of the pacing counter (derived, not overridable)

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
loadValid  input  1  host request valid
loadReady  output  1  high only in IDLE; a transfer starts on loadValid && loadReady
loadData  input  ChainLength  word to write, bit [ChainLength-1] is shifted first
rotate  input  1  sampled at accept; 1 = read-only rotate, loadData ignored
serialEn  output  1  shift-enable to the chain, registered
serialIn  output  1  data to the chain
serialOut  input  1  chain MSB (the chain's serial output)
busy  output  1  high in SHIFT and DONE
readbackValid  output  1  one-cycle pulse in DONE
readbackData  output  ChainLength  chain contents captured before this transfer; held until the next accept

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE, serialEn=0, busy=0, readbackValid=0, readbackData=0, counters=0. Only the state, counters and outputs are cleared; the chain's own register is not touched.
- States: IDLE -> SHIFT on accept; SHIFT -> DONE after the ChainLength-th shift pulse; DONE -> IDLE unconditionally after 1 cycle.
- Accept (cycle T): latch loadData into the tx register, latch rotate into rotMode, and clear bitCnt and the step counter.
- Pacing: shift pulse k (k=1..ChainLength) has serialEn=1 in cycle T+1+(k-1)*StepCycles. serialEn is 0 in all other cycles; StepCycles=1 gives back-to-back pulses.
- serialIn:
  - rotMode=0: serialIn = txReg MSB, registered; txReg shifts left by 1 after each pulse.
  - rotMode=1: serialIn = serialOut, combinational pass-through. This is legal because the chain output is registered.
  - When serialEn=0, serialIn is don't-care; drive txReg MSB.
- Capture: at the end of each cycle with serialEn=1, rxReg <= {rxReg[ChainLength-2:0], serialOut}. This samples the pre-shift chain MSB. After ChainLength pulses, rxReg equals the old chain contents.
- DONE occurs at cycle T+2+(ChainLength-1)*StepCycles:
  - readbackData <= rxReg, registered on entry to DONE;
  - readbackValid=1 for that cycle only;
  - loadReady=0.
- Latency, accept to readbackValid: 1+(ChainLength-1)*StepCycles+1 cycles (6 with the defaults).
- Boundary conditions:
  - loadValid in SHIFT or DONE: ignored and not queued. The host holds it until loadReady.
  - Earliest next accept: the cycle after DONE.
  - rotate or loadData changing mid-transfer: no effect, since both are latched at accept.
  - reset mid-transfer: takes priority at that edge. serialEn is 0 from the next cycle, no readbackValid is produced, and the state is IDLE. The chain is left partially shifted; the host must reload it.
  - bitCnt counts 0..ChainLength-1 and is compared for equality; the step counter wraps at StepCycles-1. No overflow paths exist.

Decomposition:
- Shared config package holds:
  - ClockConfigWidth=4, SymCoeffsWidth=1, ChainLength = their sum;
  - DefaultClockConfig=4'hf, DefaultSymCoeffs=1'b1;
  - the state enum {IDLE, SHIFT, DONE}.
- No sub-module: the FSM, pacing counter and two shift registers fit in one module.
- The testbench instantiates the existing chain store as the far end.

Test Plan:
1. Reset, then idle -> loadReady=1, serialEn=0, busy=0, readbackValid=0, readbackData=0.
2. Chain at default 5'h1F, load 5'h0A with rotate=0, StepCycles=1, accept at T -> serialEn=1 in T+1..T+5; serialIn = 0,1,0,1,0; readbackValid at T+6 with readbackData=5'h1F; chain clockConfig=4'hA, symCoeffs=0.
3. Then rotate=1 with loadData=5'h15 -> readbackData=5'h0A and the chain still holds 5'h0A; loadData is ignored.
4. StepCycles=3, load 5'h13 -> serialEn pulses at T+1, T+4, T+7, T+10, T+13; readbackValid at T+14; chain holds 5'h13.
5. Load 5'h00, assert reset at T+3 -> from T+4: serialEn=0, loadReady=1, busy=0; no readbackValid pulse; the chain shows 2 or 3 bits shifted.
6. loadValid held high continuously with 5'h0A then 5'h05 -> second accept at T+7 exactly (not earlier); second readbackData=5'h0A.

Source files
------------

// File: rtl/config_shift_master_pkg.sv
// Shared configuration-chain definitions: chain field widths, power-on chain
// contents and the shift master's state encoding.
package config_shift_master_pkg;

    localparam int ClockConfigWidth = 4;
    localparam int SymCoeffsWidth   = 1;
    localparam int ChainLength      = ClockConfigWidth + SymCoeffsWidth;

    localparam logic [ClockConfigWidth-1:0] DefaultClockConfig = 4'hf;
    localparam logic [SymCoeffsWidth-1:0]   DefaultSymCoeffs   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/config_shift_master.sv
// Serial master for the configuration shift chain: writes a word MSB first
// while capturing the old chain contents, or rotates the chain to read it.
module config_shift_master #(
    parameter int ChainLength = config_shift_master_pkg::ChainLength,
    parameter int StepCycles  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   loadValid,
    output logic                   loadReady,
    input  logic [ChainLength-1:0] loadData,
    input  logic                   rotate,
    output logic                   serialEn,
    output logic                   serialIn,
    input  logic                   serialOut,
    output logic                   busy,
    output logic                   readbackValid,
    output logic [ChainLength-1:0] readbackData
);
    import config_shift_master_pkg::*;

    localparam int StepCntWidth = $clog2(StepCycles + 1);
    localparam int BitCntWidth  = $clog2(ChainLength);

    state_e                   r_state;
    state_e                   w_state_next;
    logic [ChainLength-1:0]   r_tx;
    logic [ChainLength-1:0]   r_rx;
    logic [ChainLength-1:0]   r_rb;
    logic                     r_rot;
    logic                     r_en;
    logic                     r_rb_valid;
    logic [BitCntWidth-1:0]   r_bit_cnt;
    logic [StepCntWidth-1:0]  r_step_cnt;

    logic                     w_accept;
    logic                     w_last_pulse;
    logic                     w_step_wrap;
    logic [ChainLength-1:0]   w_rx_next;

    assign w_accept     = loadValid && (r_state == IDLE);
    assign w_last_pulse = r_en && (r_bit_cnt == BitCntWidth'(ChainLength - 1));
    assign w_step_wrap  = (r_step_cnt == StepCntWidth'(StepCycles - 1));
    // Sample the chain MSB before this pulse shifts it away.
    assign w_rx_next    = {r_rx[ChainLength-2:0], serialOut};

    always_comb begin
        w_state_next = r_state;
        loadReady    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                loadReady = 1'b1;
                if (w_accept) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last_pulse) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rb       <= '0;
            r_rot      <= 1'b0;
            r_en       <= 1'b0;
            r_rb_valid <= 1'b0;
            r_bit_cnt  <= '0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_en       <= 1'b0;
            r_rb_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tx       <= loadData;
                        r_rot      <= rotate;
                        r_bit_cnt  <= '0;
                        r_step_cnt <= '0;
                        r_en       <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_step_cnt <= w_step_wrap ? '0 : r_step_cnt + 1'b1;
                    if (r_en) begin
                        r_rx <= w_rx_next;
                        r_tx <= {r_tx[ChainLength-2:0], 1'b0};
                        if (!w_last_pulse) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    // The final capture goes straight to the readback register.
                    if (w_last_pulse) begin
                        r_rb       <= w_rx_next;
                        r_rb_valid <= 1'b1;
                    end else if (w_step_wrap) begin
                        r_en <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Rotate mode loops the registered chain output straight back in.
    assign serialIn      = (r_rot && r_en) ? serialOut : r_tx[ChainLength-1];
    assign serialEn      = r_en;
    assign readbackValid = r_rb_valid;
    assign readbackData  = r_rb;

endmodule

// File: tb/tb_config_shift_master.sv
// Bench for config_shift_master: two masters (StepCycles 1 and 3), each
// driving its own behavioural chain store, checked against a transfer model.
module tb_config_shift_master;
  import config_shift_master_pkg::*;

  localparam int L = ChainLength;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // master 0: StepCycles=1, master 1: StepCycles=3
  logic         lv0, rot0, lr0, en0, sin0, sout0, busy0, rv0;
  logic [L-1:0] ld0, rd0;
  logic         lv1, rot1, lr1, en1, sin1, sout1, busy1, rv1;
  logic [L-1:0] ld1, rd1;

  config_shift_master #(.ChainLength(L), .StepCycles(1)) dut0 (
    .clk(clk), .reset(reset), .loadValid(lv0), .loadReady(lr0),
    .loadData(ld0), .rotate(rot0), .serialEn(en0), .serialIn(sin0),
    .serialOut(sout0), .busy(busy0), .readbackValid(rv0), .readbackData(rd0)
  );

  config_shift_master #(.ChainLength(L), .StepCycles(3)) dut1 (
    .clk(clk), .reset(reset), .loadValid(lv1), .loadReady(lr1),
    .loadData(ld1), .rotate(rot1), .serialEn(en1), .serialIn(sin1),
    .serialOut(sout1), .busy(busy1), .readbackValid(rv1), .readbackData(rd1)
  );

  // chain stores: never reset, power up holding the default configuration
  logic [L-1:0] chain0 = {DefaultSymCoeffs, DefaultClockConfig};
  logic [L-1:0] chain1 = {DefaultSymCoeffs, DefaultClockConfig};
  always @(posedge clk) if (en0) chain0 <= {chain0[L-2:0], sin0};
  always @(posedge clk) if (en1) chain1 <= {chain1[L-2:0], sin1};
  assign sout0 = chain0[L-1];
  assign sout1 = chain1[L-1];

  // observation mux for the master under test
  int sel = 0;
  logic m_ready, m_en, m_sin, m_busy, m_rv;
  logic [L-1:0] m_rd, m_chain;
  always_comb begin
    m_ready = sel ? lr1 : lr0;
    m_en    = sel ? en1 : en0;
    m_sin   = sel ? sin1 : sin0;
    m_busy  = sel ? busy1 : busy0;
    m_rv    = sel ? rv1 : rv0;
    m_rd    = sel ? rd1 : rd0;
    m_chain = sel ? chain1 : chain0;
  end

  // reference model: chain contents per master
  logic [L-1:0] model_chain[2];
  logic [L-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [L-1:0] data, input logic r);
    if (d == 0) begin
      lv0 = v; ld0 = data; rot0 = r;
    end else begin
      lv1 = v; ld1 = data; rot1 = r;
    end
  endtask

  // One transfer with cycle-by-cycle checks of pacing, serial data and readback.
  task automatic xfer(input int d, input logic [L-1:0] data, input logic r);
    int s;
    int lat;
    int k;
    logic exp_en;
    logic [L-1:0] old_val;
    logic [L-1:0] new_val;
    s = (d == 0) ? 1 : 3;
    lat = 2 + (L - 1) * s;
    old_val = model_chain[d];
    new_val = r ? old_val : data;
    exp_q.push_back(old_val);
    sel = d;
    @(negedge clk);
    drive(d, 1'b1, data, r);
    check_eq("ready_before_accept", m_ready, 1);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) drive(d, 1'b0, L'($urandom), 1'($urandom));
      exp_en = (c <= 1 + (L - 1) * s) && ((c - 1) % s == 0);
      check_eq("serial_en", m_en, exp_en);
      check_eq("busy", m_busy, c <= lat);
      check_eq("load_ready", m_ready, c > lat);
      check_eq("readback_valid", m_rv, c == lat);
      if (exp_en) begin
        k = (c - 1) / s;
        check_eq("serial_in", m_sin, r ? old_val[L-1-k] : data[L-1-k]);
      end
      if (c == lat) check_eq("readback_data", m_rd, exp_q.pop_front());
    end
    check_eq("readback_held", m_rd, old_val);
    check_eq("chain_after", m_chain, new_val);
    model_chain[d] = new_val;
  endtask

  initial begin
    logic [L-1:0] old_val;
    logic [L-1:0] rdata;
    model_chain[0] = {DefaultSymCoeffs, DefaultClockConfig};
    model_chain[1] = {DefaultSymCoeffs, DefaultClockConfig};
    reset = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset / idle state of both masters
    for (int d = 0; d < 2; d++) begin
      sel = d;
      #1;
      check_eq("rst_ready", m_ready, 1);
      check_eq("rst_en", m_en, 0);
      check_eq("rst_busy", m_busy, 0);
      check_eq("rst_rv", m_rv, 0);
      check_eq("rst_rd", m_rd, 0);
    end

    // write, then rotate-read, at StepCycles=1
    xfer(0, 5'h0A, 1'b0);
    check_eq("clock_config", chain0[ClockConfigWidth-1:0], 4'hA);
    check_eq("sym_coeffs", chain0[L-1], 0);
    xfer(0, 5'h15, 1'b1);
    check_eq("rotate_keeps_chain", chain0, 5'h0A);

    // paced transfer at StepCycles=3
    xfer(1, 5'h13, 1'b0);

    // reset after the third pulse leaves the chain three bits shifted
    sel = 0;
    old_val = model_chain[0];
    @(negedge clk);
    drive(0, 1'b1, 5'h00, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b0, 5'h00, 1'b0);
      if (c <= 3) check_eq("pre_reset_en", m_en, 1);
      if (c == 3) reset = 1'b1;
      if (c == 4) begin
        check_eq("mid_reset_ready", m_ready, 1);
        check_eq("mid_reset_busy", m_busy, 0);
        reset = 1'b0;
      end
      if (c >= 4) begin
        check_eq("mid_reset_en", m_en, 0);
        check_eq("mid_reset_rv", m_rv, 0);
      end
    end
    model_chain[0] = old_val << 3;
    check_eq("chain_partial", chain0, model_chain[0]);

    // loadValid held high across two transfers: no early second accept
    sel = 0;
    old_val = model_chain[0];
    @(negedge clk);
    drive(0, 1'b1, 5'h0A, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b1, 5'h05, 1'b0);
      check_eq("held_en", m_en, (c <= 5) || (c >= 8 && c <= 12));
      check_eq("held_ready", m_ready, c == 7);
      check_eq("held_rv", m_rv, (c == 6) || (c == 13));
      if (c == 6) check_eq("held_rd1", m_rd, old_val);
      if (c == 13) check_eq("held_rd2", m_rd, 5'h0A);
      if (c == 8) drive(0, 1'b0, 5'h00, 1'b0);
    end
    model_chain[0] = 5'h05;
    check_eq("held_chain", chain0, 5'h05);

    // random transfers on both masters
    for (int i = 0; i < 20; i++) begin
      int d;
      d = $urandom_range(0, 1);
      rdata = L'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xfer(d, rdata, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
